// File: rtl/shake_rej_pkg.sv
// Shared types and constants for the SHAKE rejection sampler.
// Holds the FSM state enum, lane constants and parameter defaults.
package shake_rej_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN,
      FIN
   } state_t;

   localparam int LANE_W = 2;
   localparam logic [LANE_W-1:0] LANE_FIRST = 2'd0;
   localparam logic [LANE_W-1:0] LANE_LAST = 2'd3;

   localparam int DEF_Q = 251;
   localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/shake_byte_unpacker.sv
// Holds one squeeze word and walks its bytes, lane 0 = bits [7:0].
// Ports: clk, rst (async active-low), load/din capture a word and rewind
// to lane 0, advance steps one lane, cur_byte/last expose the current lane.
module shake_byte_unpacker
   import shake_rej_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        advance,
   input  logic [31:0] din,
   output logic [7:0]  cur_byte,
   output logic        last
);

   logic [31:0]       word_r;
   logic [LANE_W-1:0] lane;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_r <= '0;
         lane   <= LANE_FIRST;
      end else if (load) begin
         word_r <= din;
         lane   <= LANE_FIRST;
      end else if (advance) begin
         lane   <= lane + 1'b1;
      end
   end

   assign cur_byte = word_r[{lane, 3'b000} +: 8];
   assign last     = (lane == LANE_LAST);

endmodule

// File: rtl/shake_rej_sampler.sv
// Rejection sampler on the SHAKE squeeze stream: unpacks 32-bit words
// into bytes, keeps those below Q and emits exactly req_count of them.
// Ports: clk, rst (async active-low), start/req_count/busy control,
// din/din_valid/din_ready from the core, force_done to the core,
// elem/elem_valid/elem_ready to the consumer, done pulse at the end.
// Build option SHAKE_REJ_STATS_EN adds reject_cnt (saturating count of
// rejected bytes in the current request).
module shake_rej_sampler
   import shake_rej_pkg::*;
#(
   parameter int Q     = DEF_Q,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] req_count,
   output logic             busy,
   input  logic [31:0]      din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             force_done,
   output logic [7:0]       elem,
   output logic             elem_valid,
   input  logic             elem_ready,
   output logic             done
`ifdef SHAKE_REJ_STATS_EN
   ,
   output logic [CNT_W-1:0] reject_cnt
`endif
);

   // 9-bit threshold so Q=256 accepts every byte.
   localparam logic [8:0] Q9 = 9'(Q);

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] remain;
   logic [7:0]       cur_byte;
   logic             last;
   logic             load;
   logic             advance;
   logic             accept;

   shake_byte_unpacker u_unpack (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .advance  (advance),
      .din      (din),
      .cur_byte (cur_byte),
      .last     (last)
   );

   assign accept = ({1'b0, cur_byte} < Q9);
   assign busy   = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         remain <= '0;
      end else begin
         state <= state_n;
         if (state == IDLE && start) begin
            remain <= req_count;
         end else if (state == SCAN && accept && elem_ready
                      && remain != '0) begin
            remain <= remain - 1'b1;
         end
      end
   end

   always_comb begin
      state_n    = state;
      din_ready  = 1'b0;
      load       = 1'b0;
      advance    = 1'b0;
      elem_valid = 1'b0;
      elem       = 8'h00;
      force_done = 1'b0;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = (req_count == '0) ? FIN : LOAD;
            end
         end
         LOAD: begin
            din_ready = 1'b1;
            if (din_valid) begin
               load    = 1'b1;
               state_n = SCAN;
            end
         end
         SCAN: begin
            if (accept) begin
               // Lane holds until the transfer, so elem stays stable.
               elem_valid = 1'b1;
               elem       = cur_byte;
               if (elem_ready) begin
                  if (remain <= 1) begin
                     state_n = FIN;
                  end else if (last) begin
                     state_n = LOAD;
                  end else begin
                     advance = 1'b1;
                  end
               end
            end else if (last) begin
               state_n = LOAD;
            end else begin
               advance = 1'b1;
            end
         end
         FIN: begin
            force_done = 1'b1;
            done       = 1'b1;
            state_n    = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

`ifdef SHAKE_REJ_STATS_EN
   logic rej;
   assign rej = (state == SCAN) && !accept;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reject_cnt <= '0;
      end else if (state == IDLE && start) begin
         reject_cnt <= '0;
      end else if (rej && reject_cnt != '1) begin
         reject_cnt <= reject_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_shake_rej_sampler.sv
// Self-checking bench for shake_rej_sampler: directed and random
// requests compared against a byte-list model of rejection sampling.
module tb_shake_rej_sampler;

   localparam int Q     = 251;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [CNT_W-1:0] req_count;
   logic             busy;
   logic [31:0]      din;
   logic             din_valid;
   logic             din_ready;
   logic             force_done;
   logic [7:0]       elem;
   logic             elem_valid;
   logic             elem_ready;
   logic             done;
`ifdef SHAKE_REJ_STATS_EN
   logic [CNT_W-1:0] reject_cnt;
`endif

   shake_rej_sampler #(.Q(Q), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .req_count  (req_count),
      .busy       (busy),
      .din        (din),
      .din_valid  (din_valid),
      .din_ready  (din_ready),
      .force_done (force_done),
      .elem       (elem),
      .elem_valid (elem_valid),
      .elem_ready (elem_ready),
      .done       (done)
`ifdef SHAKE_REJ_STATS_EN
      ,
      .reject_cnt (reject_cnt)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic [31:0] words[$];
   logic [7:0]  exp_q[$];
   int          exp_words;
   int          exp_rej;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Walk the words byte by byte, keep bytes below Q until cnt kept.
   task automatic model_run(input int cnt);
      logic [7:0] b;
      exp_q.delete();
      exp_words = 0;
      exp_rej   = 0;
      for (int w = 0; w < words.size() && exp_q.size() < cnt; w++) begin
         exp_words++;
         for (int l = 0; l < 4 && exp_q.size() < cnt; l++) begin
            b = 8'(words[w] >> (8 * l));
            if (int'(b) < Q) exp_q.push_back(b);
            else exp_rej++;
         end
      end
   endtask

   // rmode: 0 always ready, 1 random ready, 2 ready low 3 valid cycles
   task automatic run_req(input int cnt, input int rmode,
                          input string name);
      logic [7:0] got[$];
      int         wi = 0;
      int         hs = 0;
      int         cyc = 0;
      int         last_x = 0;
      int         done_cyc = -1;
      int         hold = 0;
      logic       pv = 1'b0;
      logic [7:0] pe = 8'h00;
      bit         fin = 1'b0;
      int         exp_done;
      model_run(cnt);
      @(negedge clk);
      start     = 1'b1;
      req_count = CNT_W'(cnt);
      @(posedge clk);
      #1;
      start     = 1'b0;
      req_count = CNT_W'($urandom);
      while (!fin && cyc < 2000) begin
         cyc++;
         din_valid = (wi < words.size())
                     && (rmode == 0 || $urandom_range(3) != 0);
         din = din_valid ? words[wi] : $urandom;
         case (rmode)
            0: elem_ready = 1'b1;
            1: elem_ready = 1'($urandom_range(1));
            default: begin
               elem_ready = (hold >= 3);
               if (elem_valid) hold++;
            end
         endcase
         #1;
         if (pv) begin
            chk({name, " hold_valid"}, 32'(elem_valid), 32'd1);
            chk({name, " hold_elem"}, 32'(elem), 32'(pe));
         end
         if (din_ready && din_valid) begin
            hs++;
            wi++;
         end
         if (elem_valid && elem_ready) begin
            got.push_back(elem);
            last_x = cyc;
         end
         pv = elem_valid && !elem_ready;
         pe = elem;
         if (done) begin
            done_cyc = cyc;
            fin = 1'b1;
            chk({name, " force_done"}, 32'(force_done), 32'd1);
         end
         @(posedge clk);
         #1;
      end
      din_valid  = 1'b0;
      elem_ready = 1'b0;
      chk({name, " done_seen"}, 32'(fin), 32'd1);
      exp_done = (cnt == 0) ? 1 : last_x + 1;
      chk({name, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
      chk({name, " n_elems"}, 32'(got.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got.size())
            chk($sformatf("%s elem%0d", name, i), 32'(got[i]),
                32'(exp_q[i]));
      end
      chk({name, " handshakes"}, 32'(hs), 32'(exp_words));
      #1;
      chk({name, " idle_busy"}, 32'(busy), 32'd0);
      chk({name, " idle_done"}, 32'(done | force_done), 32'd0);
`ifdef SHAKE_REJ_STATS_EN
      chk({name, " reject_cnt"}, 32'(reject_cnt), 32'(exp_rej));
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int acc;
      int steps;
      logic [31:0] w;
      logic [7:0]  bt;
      rst        = 1'b0;
      start      = 1'b0;
      req_count  = '0;
      din        = '0;
      din_valid  = 1'b0;
      elem_ready = 1'b0;
      #3;
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst din_ready", 32'(din_ready), 32'd0);
      chk("rst force_done", 32'(force_done), 32'd0);
      chk("rst elem_valid", 32'(elem_valid), 32'd0);
      chk("rst elem", 32'(elem), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      words = '{32'h03FC_FB02, 32'h0000_0000};
      run_req(2, 0, "t_reject");
      words = '{32'h0403_0201, 32'h0807_0605, 32'h0};
      run_req(5, 0, "t_two_words");
      words = '{32'hFFFF_FFFF, 32'h0000_0010};
      run_req(1, 0, "t_all_rej");
      words = '{32'h0000_0042};
      run_req(1, 2, "t_backpressure");
      words = '{32'h1111_1111};
      run_req(0, 0, "t_zero");
      words = '{32'hFBFA_FBFA, 32'h0000_0001, 32'h0};
      run_req(3, 1, "t_q_edge");

      // reset while an accepted element waits for the consumer
      @(negedge clk);
      start     = 1'b1;
      req_count = 16'd1;
      @(posedge clk);
      #1;
      start      = 1'b0;
      din        = 32'h0000_0042;
      din_valid  = 1'b1;
      elem_ready = 1'b0;
      steps = 0;
      while (!elem_valid && steps < 50) begin
         @(posedge clk);
         #1;
         din_valid = 1'b0;
         steps++;
      end
      chk("mid valid_reached", 32'(elem_valid), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid busy", 32'(busy), 32'd0);
      chk("mid din_ready", 32'(din_ready), 32'd0);
      chk("mid elem_valid", 32'(elem_valid), 32'd0);
      chk("mid elem", 32'(elem), 32'd0);
      chk("mid done", 32'(done | force_done), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      words = '{32'h0000_0007};
      run_req(1, 0, "t_after_rst");

      for (int it = 0; it < 20; it++) begin
         cnt = $urandom_range(12, 1);
         words.delete();
         acc = 0;
         while (acc < cnt) begin
            w = $urandom;
            for (int l = 0; l < 4; l++) begin
               if ($urandom_range(2) == 0) begin
                  bt = 8'($urandom_range(255, 245));
                  w = (w & ~(32'hFF << (8 * l)))
                      | (32'(bt) << (8 * l));
               end
               bt = 8'(w >> (8 * l));
               if (int'(bt) < Q) acc++;
            end
            words.push_back(w);
         end
         words.push_back($urandom);
         run_req(cnt, 1, $sformatf("rnd%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shake_rej_sampler.md
# shake_rej_sampler

Downstream consumer of the SHAKE core's 32-bit squeeze stream. It unpacks each output word into bytes in software byte order and rejection-samples them against a modulus `Q`. It emits exactly the requested number of accepted elements on a valid/ready byte port. Once the count is met it pulses `force_done` to stop the core's squeezing. In the SDitH datapath it sits between the Keccak core and the field-element consumers (share/challenge generators).

## Interface
Parameters:
- `Q`, 251: a byte `b` is accepted iff `b < Q`; legal range 2..256 (256 disables rejection).
- `CNT_W`, 16: width of element counters.

Ports (clock and reset first):
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous assert, active-low (0 = reset).
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `req_count`  in  CNT_W  number of accepted elements wanted; latched on `start`.
- `busy`  out  1  high in every state except IDLE.
- `din`  in  32  squeeze word; connects to core `dout`.
- `din_valid`  in  1  connects to core `dout_valid`.
- `din_ready`  out  1  connects to core `dout_ready`.
- `force_done`  out  1  one-cycle pulse to core `force_done`.
- `elem`  out  8  accepted element.
- `elem_valid`  out  1  `elem` is valid.
- `elem_ready`  in  1  consumer accepts `elem`.
- `done`  out  1  one-cycle pulse when `req_count` elements have been transferred.

Reset values: `busy`, `din_ready`, `force_done`, `elem_valid` and `done` are 0; `elem` is 8'h00.

## Operation
- **States:** IDLE, LOAD, SCAN, FIN.
- **IDLE:**
  - On `start` with `req_count`=0: go to FIN.
  - On `start` with `req_count`>0: latch the count into `remain` and go to LOAD.
  - `start` is ignored outside IDLE.
- **LOAD:** `din_ready`=1. When `din_valid`&&`din_ready`, capture `din` into `word_r`, set `lane`=0 and go to SCAN.
- **SCAN (one lane per cycle):**
  - Lane byte order is `word_r[7:0]`, `[15:8]`, `[23:16]`, `[31:24]` for `lane` 0..3.
  - Rejected byte (`b >= Q`): advance `lane` next cycle. `elem_valid` stays 0 for that cycle.
  - Accepted byte: drive `elem`=b, `elem_valid`=1. Hold `elem`/`elem_valid` stable until `elem_ready`.
  - On the transfer: decrement `remain`, then
    - `remain` becomes 0: go to FIN.
    - else `lane`=3: go to LOAD.
    - else: advance `lane`.
  - After a rejected byte on lane 3: go to LOAD.
- **FIN:** pulse `force_done`=1 and `done`=1 for exactly one cycle, then return to IDLE. Unconsumed lanes of `word_r` are discarded.
- **Arithmetic:** `remain` is CNT_W bits, unsigned, and never wraps (decremented only when nonzero). The comparison `b < Q` is done at 9 bits.
- **Reset mid-operation:** everything returns to IDLE immediately. No `force_done` or `done` is emitted, and any partial word is lost.

## Timing
- `start` accepted at edge 0; `din_ready`=1 from cycle 1.
- A word accepted at edge k gives lane 0 `elem_valid` at cycle k+1, when accepted.
- Best-case throughput is 4 elements per 5 cycles (one LOAD cycle per word); `din_ready` is never high in SCAN.
- Backpressure: `elem_valid` never deasserts without a transfer, and `elem` never changes while `elem_valid`&&!`elem_ready`.
- `done` and `force_done` are high in the same cycle, one cycle after the final transfer.
- `req_count`=0 gives `done` at cycle 1 after `start`, with no `din_ready`.

## Configuration
- `SHAKE_REJ_STATS_EN` defined:
  - Adds output `reject_cnt` (CNT_W), cleared on `start` and saturating at all-ones.
  - It counts rejected bytes examined during the current request and holds its value in IDLE until the next `start`.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

## Structure
- Package `shake_rej_pkg`: state enum (IDLE/LOAD/SCAN/FIN), lane constants, default `Q`=251, `CNT_W`=16.
- One sub-module, `shake_byte_unpacker`: holds `word_r` and `lane`, and presents the current byte plus a last-lane flag. The FSM and counters stay in the top.

## Test plan
- Q=251, `req_count`=2, word 32'h03FC_FB02 → elems 8'h02 then 8'h03; FB and FC rejected; `done`+`force_done` pulse one cycle after the 2nd transfer; `reject_cnt`=2 with stats enabled.
- `req_count`=5, words 32'h04030201 then 32'h08070605, `elem_ready`=1 → 01,02,03,04,05; second word lanes 1–3 discarded; exactly two `din_ready` handshakes.
- Word 32'hFFFFFFFF then 32'h00000010, `req_count`=1 → first word fully rejected, LOAD re-entered, elem 8'h10.
- Backpressure: `elem_ready` low for 3 cycles on the first element of 32'h00000042 → `elem` holds 8'h42 with `elem_valid` high throughout; single transfer.
- `req_count`=0 → `done` and `force_done` at cycle 1; `din_ready` never asserted.
- Assert `rst`=0 during SCAN with `elem_valid` high → all outputs 0 asynchronously; after release, a new `start` with `req_count`=1 on word 32'h00000007 yields 8'h07.
